// File: rtl/fb_plot_sink.sv
// Plot-request sink: buffers plot/x/y/colour requests in a small FIFO, writes them into a
// WIDTH x HEIGHT 3-bit framebuffer, fills it on clear, and scans it out as a raster stream.
module fb_plot_sink #(
    parameter int         WIDTH      = 160,
    parameter int         HEIGHT     = 120,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [2:0] BG_COLOUR  = 3'd0
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       plot,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    output logic       ready,
    input  logic       clear,
    output logic       busy,
    output logic       oob,
    input  logic       scan_en,
    output logic [2:0] pix_colour,
    output logic       pix_valid,
    output logic       line_start,
    output logic       frame_start
);
    // state   | meaning
    // S_IDLE  | pop FIFO one entry per cycle, write in-range requests
    // S_DRAIN | clear accepted, finish popping the FIFO with ready held low
    // S_CLEAR | write BG_COLOUR to every address, then back to idle
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int AW   = $clog2(NPIX);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

    state_t        state;
    logic [AW-1:0] clr_addr;

    logic [17:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    logic [7:0]    head_x;
    logic [6:0]    head_y;
    logic [2:0]    head_c;
    logic          head_in_range;

    logic [2:0]    fb [NPIX];
    logic          we;
    logic [AW-1:0] waddr;
    logic [2:0]    wdata;

    logic [7:0]    col;
    logic [6:0]    row;
    logic [AW-1:0] raddr;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign ready = !full && (state == S_IDLE);
    assign busy  = (state != S_IDLE);
    assign push  = plot && ready;
    assign pop   = !empty && (state != S_CLEAR);

    assign {head_x, head_y, head_c} = fifo_mem[rd_ptr];
    assign head_in_range = (int'(head_x) < WIDTH) && (int'(head_y) < HEIGHT);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {x, y, colour};
        end
    end

    // Clear writes and request writes never overlap: no pops happen in S_CLEAR.
    always_comb begin
        we    = 1'b0;
        waddr = clr_addr;
        wdata = BG_COLOUR;
        if (state == S_CLEAR) begin
            we = 1'b1;
        end else if (pop && head_in_range) begin
            we    = 1'b1;
            waddr = AW'(head_y) * AW'(WIDTH) + AW'(head_x);
            wdata = head_c;
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            fb[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            clr_addr <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            oob      <= 1'b0;
        end else begin
            count <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                if (!head_in_range) begin
                    oob <= 1'b1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        clr_addr <= '0;
                        state    <= (count_nxt == '0) ? S_CLEAR : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (count_nxt == '0) begin
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (clr_addr == AW'(NPIX - 1)) begin
                        state <= S_IDLE;
                        oob   <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + AW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign raddr = AW'(row) * AW'(WIDTH) + AW'(col);

    // Read port is independent of writes; a same-address write lands after the read.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col         <= '0;
            row         <= '0;
            pix_colour  <= 3'd0;
            pix_valid   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= scan_en;
            line_start  <= scan_en && (col == '0);
            frame_start <= scan_en && (col == '0) && (row == '0);
            if (scan_en) begin
                pix_colour <= fb[raddr];
                if (int'(col) == WIDTH - 1) begin
                    col <= '0;
                    row <= (int'(row) == HEIGHT - 1) ? '0 : row + 7'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fb_plot_sink.sv
// Bench for fb_plot_sink: a vector table for back-to-back plots and oob, a framebuffer
// model feeding a scan scoreboard, and hand sequences for clear, latency and reset.
module tb_fb_plot_sink;
    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;

    logic       clock   = 1'b0;
    logic       resetn  = 1'b0;
    logic       plot    = 1'b0;
    logic       clear   = 1'b0;
    logic       scan_en = 1'b0;
    logic [7:0] x       = 8'd0;
    logic [6:0] y       = 7'd0;
    logic [2:0] colour  = 3'd0;
    logic       ready;
    logic       busy;
    logic       oob;
    logic [2:0] pix_colour;
    logic       pix_valid;
    logic       line_start;
    logic       frame_start;

    fb_plot_sink dut (
        .clock      (clock),
        .resetn     (resetn),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .ready      (ready),
        .clear      (clear),
        .busy       (busy),
        .oob        (oob),
        .scan_en    (scan_en),
        .pix_colour (pix_colour),
        .pix_valid  (pix_valid),
        .line_start (line_start),
        .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         addr;
        logic [2:0] col;
        logic       ls;
        logic       fs;
    } pix_t;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       exp_oob;
    } vec_t;

    pix_t       sb_q[$];
    logic [2:0] model [NPIX];
    int         errors = 0;
    int         checks = 0;
    int         scol = 0;
    int         srow = 0;
    int         hs_cnt = 0;
    int         wr_cnt = 0;
    logic       last_hs = 1'b0;
    logic       use_manual = 1'b0;
    logic [2:0] manual_col = 3'd0;
    int         ls_seen = 0;
    int         fs_seen = 0;
    int         nz_seen = 0;
    logic [2:0] cap0, cap483, cap9290, cap19199;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: note what the DUT samples at the edge, update the models, settle 1 time unit.
    task automatic tick();
        logic hs;
        logic clr_acc;
        logic sc;
        int   a;
        hs      = plot && ready;
        clr_acc = clear && !busy;
        sc      = scan_en;
        @(posedge clock);
        last_hs = hs;
        if (hs) begin
            hs_cnt++;
            if (int'(x) < W && int'(y) < H) begin
                model[int'(y) * W + int'(x)] = colour;
                wr_cnt++;
            end
        end
        if (clr_acc) begin
            for (int i = 0; i < NPIX; i++) model[i] = 3'd0;
            wr_cnt = 0;
        end
        if (sc) begin
            a = srow * W + scol;
            sb_q.push_back('{a, use_manual ? manual_col : model[a], scol == 0, scol == 0 && srow == 0});
            if (scol == W - 1) begin
                scol = 0;
                srow = (srow == H - 1) ? 0 : srow + 1;
            end else begin
                scol++;
            end
        end
        #1;
    endtask

    always @(negedge clock) begin
        pix_t e;
        if (resetn) begin
            if (pix_valid) begin
                if (sb_q.size() == 0) begin
                    chk("pix_valid_spurious", pix_valid, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("pix_colour@%0d", e.addr), pix_colour, e.col);
                    chk($sformatf("line_start@%0d", e.addr), line_start, e.ls);
                    chk($sformatf("frame_start@%0d", e.addr), frame_start, e.fs);
                    if (line_start) ls_seen++;
                    if (frame_start) fs_seen++;
                    if (pix_colour != 3'd0) nz_seen++;
                    if (e.addr == 0) cap0 = pix_colour;
                    if (e.addr == 483) cap483 = pix_colour;
                    if (e.addr == 9290) cap9290 = pix_colour;
                    if (e.addr == NPIX - 1) cap19199 = pix_colour;
                end
            end else if (sb_q.size() != 0) begin
                void'(sb_q.pop_front());
                chk("pix_valid_missing", pix_valid, 1);
            end
        end
    end

    initial begin
        vec_t vecs[4];
        int   n;
        int   rdy_hi;
        int   hs_busy;
        vecs[0] = '{8'd159, 7'd119, 3'd5, 1'b0};
        vecs[1] = '{8'd0,   7'd0,   3'd7, 1'b0};
        vecs[2] = '{8'd160, 7'd0,   3'd3, 1'b1};
        vecs[3] = '{8'd5,   7'd120, 3'd3, 1'b1};

        // reset values
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_oob", oob, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_line_start", line_start, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_pix_colour", pix_colour, 0);
        @(negedge clock) resetn = 1'b1;
        @(posedge clock);
        #1;
        chk("ready_after_reset", ready, 1);

        // out-of-range request before any clear sets oob
        plot = 1'b1; x = 8'd160; y = 7'd0; colour = 3'd3;
        tick();
        chk("pre_oob_accept", last_hs, 1);
        plot = 1'b0;
        tick();
        chk("pre_oob_set", oob, 1);

        // clear with a same-cycle plot, held request and a second clear during busy
        clear = 1'b1; plot = 1'b1; x = 8'd3; y = 7'd3; colour = 3'd4;
        tick();
        chk("clear_plot_accept", last_hs, 1);
        chk("busy_on_clear", busy, 1);
        chk("ready_on_clear", ready, 0);
        x = 8'd10; y = 7'd58; colour = 3'd2;
        n = 0; rdy_hi = 0; hs_busy = 0;
        while (busy && n < 25000) begin
            clear = (n == 5000);
            tick();
            n++;
            if (busy && ready) rdy_hi++;
            if (last_hs) hs_busy++;
        end
        clear = 1'b0;
        chk("clear_cycles", n, NPIX + 1);
        chk("ready_high_while_busy", rdy_hi, 0);
        chk("accepted_while_busy", hs_busy, 0);
        chk("oob_cleared", oob, 0);
        chk("ready_after_clear", ready, 1);
        tick();
        chk("held_accept", last_hs, 1);

        // back-to-back vectors, ready must stay high
        for (int i = 0; i < 4; i++) begin
            plot = 1'b1; x = vecs[i].x; y = vecs[i].y; colour = vecs[i].c;
            tick();
            chk($sformatf("vec%0d_accept", i), last_hs, 1);
            if (i > 0) chk($sformatf("vec%0d_oob", i - 1), oob, vecs[i - 1].exp_oob);
        end
        plot = 1'b0;
        tick();
        chk("vec3_oob", oob, vecs[3].exp_oob);

        // full-frame scan
        ls_seen = 0; fs_seen = 0; nz_seen = 0;
        scan_en = 1'b1;
        repeat (NPIX) tick();
        scan_en = 1'b0;
        tick();
        chk("frame_start_count", fs_seen, 1);
        chk("line_start_count", ls_seen, H);
        chk("pix_0", cap0, 7);
        chk("pix_3_3", cap483, 0);
        chk("pix_9290", cap9290, 2);
        chk("pix_19199", cap19199, 5);
        chk("written_vs_accepted", nz_seen, wr_cnt);

        // read-during-write returns old data; minimum write-to-read latency
        use_manual = 1'b1;
        scan_en = 1'b1; manual_col = 3'd7;
        tick();
        scan_en = 1'b0; plot = 1'b1; x = 8'd1; y = 7'd0; colour = 3'd6;
        tick();
        chk("rdw_a_accept", last_hs, 1);
        x = 8'd3; colour = 3'd5; scan_en = 1'b1; manual_col = 3'd0;
        tick();
        chk("rdw_b_accept", last_hs, 1);
        plot = 1'b0; manual_col = 3'd0;
        tick();
        manual_col = 3'd5;
        tick();
        scan_en = 1'b0; use_manual = 1'b0;
        tick();
        tick();
        chk("pix_valid_idle", pix_valid, 0);
        chk("pix_colour_hold", pix_colour, 5);

        // reset in the middle of a clear
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (1000) tick();
        chk("busy_mid_clear", busy, 1);
        chk("oob_before_reset", oob, 1);
        #2 resetn = 1'b0;
        scol = 0; srow = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_oob", oob, 0);
        chk("mid_rst_pix_valid", pix_valid, 0);
        chk("mid_rst_line_start", line_start, 0);
        chk("mid_rst_frame_start", frame_start, 0);
        chk("mid_rst_pix_colour", pix_colour, 0);
        @(negedge clock) resetn = 1'b1;
        @(posedge clock);
        #1;
        chk("ready_after_mid_reset", ready, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n = 0;
        while (busy && n < 25000) begin
            tick();
            n++;
        end
        chk("clear_cycles_after_reset", n, NPIX);
        chk("ready_after_final_clear", ready, 1);
        scan_en = 1'b1;
        tick();
        scan_en = 1'b0;
        tick();
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
